// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, iterative-unit state type and op classification helper
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0,
                           OP_SUB   = 5'd1,
                           OP_AND   = 5'd2,
                           OP_OR    = 5'd3,
                           OP_SRL   = 5'd4,
                           OP_SRA   = 5'd5,
                           OP_SLL   = 5'd6,
                           OP_SLT   = 5'd7,
                           OP_SLTU  = 5'd8,
                           OP_NOR   = 5'd9,
                           OP_XOR   = 5'd10,
                           OP_PASSA = 5'd11,
                           OP_PASSB = 5'd12,
                           OP_MFHI  = 5'd13,
                           OP_MFLO  = 5'd14,
                           OP_MTHI  = 5'd15,
                           OP_MTLO  = 5'd16,
                           OP_MULT  = 5'd17,
                           OP_MULTU = 5'd18,
                           OP_DIV   = 5'd19,
                           OP_DIVU  = 5'd20;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // True for the ops that occupy the iterative unit and raise Busy.
    function automatic logic is_md_op(input logic [4:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/md_iter.sv
// rtl/md_iter.sv - iterative shift-add multiplier / restoring divider sharing one adder
//
// Ports:
//   clk, reset_i        clock, asynchronous active-high reset
//   start_i             accepted MULT/DIV issue (only honoured while idle)
//   div_i, signed_i     operation kind latched at issue
//   a_i, b_i            operands latched at issue
//   busy_o              registered, high while iterating
//   done_o              high during the final iteration cycle
//   hi_o, lo_o          final sign-fixed result, valid while done_o is high
module md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] m_q, m_d;         // multiplicand or divisor magnitude
    logic             div_q, div_d;
    logic             neg_q, neg_d;     // negate product or quotient at completion
    logic             negr_q, negr_d;   // negate remainder at completion
    logic             div0_q, div0_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign a_neg = signed_i & a_i[WIDTH-1];
    assign b_neg = signed_i & b_i[WIDTH-1];
    assign mag_a = a_neg ? -a_i : a_i;
    assign mag_b = b_neg ? -b_i : b_i;

    // Single WIDTH+1-bit adder/subtractor with carry out. When dividing it
    // subtracts the divisor from the shifted remainder; the carry out is the
    // "no borrow" flag that decides restore vs keep.
    logic [WIDTH:0]   add_a, add_b;
    logic [WIDTH+1:0] add_s;

    assign add_a = div_q ? {acc_q, lo_q[WIDTH-1]} : {1'b0, acc_q};
    assign add_b = div_q ? ~{1'b0, m_q} : (lo_q[0] ? {1'b0, m_q} : '0);
    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, div_q};

    assign busy_o = (state_q == MD_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        m_d     = m_q;
        div_d   = div_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        div0_d  = div0_q;
        done_o  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    div_d   = div_i;
                    neg_d   = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    div0_d  = (b_i == '0);
                    lo_d    = div_i ? mag_a : mag_b;
                    m_d     = div_i ? mag_b : mag_a;
                end
            end
            MD_RUN: begin
                if (div_q) begin
                    acc_d = add_s[WIDTH+1] ? add_s[WIDTH-1:0] : add_a[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], add_s[WIDTH+1]};
                end else begin
                    acc_d = add_s[WIDTH:1];
                    lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    done_o  = 1'b1;
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Sign fix-up on the values produced by the final iteration. A zero
    // divisor leaves the dividend magnitude in the remainder, so only the
    // quotient needs forcing.
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        hi_o     = '0;
        lo_o     = '0;
        prod_fix = neg_q ? -{acc_d, lo_d} : {acc_d, lo_d};
        if (div_q) begin
            lo_o = div0_q ? '1 : (neg_q ? -lo_d : lo_d);
            hi_o = negr_q ? -acc_d : acc_d;
        end else begin
            hi_o = prod_fix[2*WIDTH-1:WIDTH];
            lo_o = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - execute-stage ALU with iterative multiply/divide and HI/LO registers
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   A, B                operands (shift amount in A[SHW-1:0])
//   Op                  operation select
//   Start               issue strobe for MTHI/MTLO/MULT/DIV codes
//   Out, Zero           combinational result and Out==0 flag
//   Busy                multiply/divide in progress
//   Hi, Lo              HI/LO register contents
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Op,
    input  logic             Start,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Busy,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             md_start, md_div, md_signed;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;

    // Start is only honoured while the iterative unit is idle; a strobe
    // during Busy is dropped rather than queued.
    assign accept    = Start & ~md_busy;
    assign md_start  = accept & is_md_op(Op);
    assign md_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    assign md_signed = (Op == OP_MULT) || (Op == OP_DIV);

    md_iter #(
        .WIDTH(WIDTH)
    ) u_md_iter (
        .clk      (clk),
        .reset_i  (reset),
        .start_i  (md_start),
        .div_i    (md_div),
        .signed_i (md_signed),
        .a_i      (A),
        .b_i      (B),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .hi_o     (md_hi),
        .lo_o     (md_lo)
    );

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_done) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end else if (accept && (Op == OP_MTHI)) begin
            hi_d = A;
        end else if (accept && (Op == OP_MTLO)) begin
            lo_d = A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    logic [SHW-1:0]          sa;
    logic signed [WIDTH-1:0] sra_res;

    assign sa      = A[SHW-1:0];
    assign sra_res = $signed(B) >>> sa;

    always_comb begin
        Out = '0;
        case (Op)
            OP_ADD:   Out = A + B;
            OP_SUB:   Out = A - B;
            OP_AND:   Out = A & B;
            OP_OR:    Out = A | B;
            OP_SRL:   Out = B >> sa;
            OP_SRA:   Out = sra_res;
            OP_SLL:   Out = B << sa;
            OP_SLT:   Out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  Out = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_NOR:   Out = ~(A | B);
            OP_XOR:   Out = A ^ B;
            OP_PASSA: Out = A;
            OP_PASSB: Out = B;
            OP_MFHI:  Out = hi_q;
            OP_MFLO:  Out = lo_q;
            default:  Out = '0;
        endcase
    end

    assign Zero = (Out == '0);
    assign Busy = md_busy;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised execute-stage ALU that keeps the established single-cycle operation set and adds a multi-cycle multiply/divide unit with architectural HI/LO registers. Combinational results appear on `Out` in the same cycle. MULT/MULTU/DIV/DIVU run iteratively behind a `Busy` flag, and the pipeline stalls on that flag. The block sits in the EX stage in place of the plain ALU.

## Interface
- `WIDTH`, 32, datapath width; must be ≥ 4 and a power of two.
- `SHW`, `$clog2(WIDTH)`, shift-amount width; derived, do not override.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `A`  in  WIDTH  operand A (shift amount in `A[SHW-1:0]`).
- `B`  in  WIDTH  operand B.
- `Op`  in  5  operation select.
- `Start`  in  1  issue strobe for sequential ops (codes 15–20); ignored for all other codes.
- `Out`  out  WIDTH  combinational result.
- `Zero`  out  1  combinational; `Out == 0`.
- `Busy`  out  1  registered; multiply/divide in progress.
- `Hi`, `Lo`  out  WIDTH each  current HI/LO register contents.

## Operation
- Combinational ops, same cycle:
  - 0 `A+B`; 1 `A-B`; 2 `A&B`; 3 `A|B`.
  - 4 `B>>sa` (logical); 5 `B>>>sa` (arithmetic); 6 `B<<sa`, where sa = `A[SHW-1:0]`.
  - 7 signed `A<B` → 1/0; 8 unsigned `A<B` → 1/0.
  - 9 `~(A|B)`; 10 `A^B`; 11 `A`; 12 `B`.
  - 13 MFHI → `Out` = HI; 14 MFLO → `Out` = LO.
  - Codes 15–31 → `Out` = 0. Never X.
- Sequential ops, acted on only when `Start`=1 and `Busy`=0:
  - 15 MTHI: HI ← A at the edge.
  - 16 MTLO: LO ← A at the edge.
  - Neither MTHI nor MTLO raises `Busy`.
  - 17 MULT / 18 MULTU: {HI,LO} ← A×B, signed/unsigned, 2·WIDTH-bit product.
  - 19 DIV / 20 DIVU: LO ← quotient, HI ← remainder.
- Signed multiply/divide:
  - Operands are converted to magnitudes at issue; the result signs are fixed at completion.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (signed or unsigned): LO ← all ones, HI ← A.
- Signed MIN ÷ −1: LO ← MIN, HI ← 0.
- `Start` while `Busy`=1 is ignored entirely: no queueing, no error.
- MFHI/MFLO while `Busy`=1 return the old HI/LO. Stalling is the pipeline's responsibility.
- Reset, including mid-operation: HI=0, LO=0, `Busy`=0, iteration counter=0, internal partials=0. Any in-flight op is discarded.

## Timing
- Combinational ops: zero latency; `Out` and `Zero` settle within the cycle.
- MTHI/MTLO: `Hi`/`Lo` show the new value in the cycle after the accepting edge.
- MULT/DIV are accepted at edge k:
  - `Busy` is 1 for exactly WIDTH cycles (edges k+1 … k+WIDTH perform one radix-2 step each).
  - HI/LO are written at edge k+WIDTH; `Busy` falls at that same edge.
  - A new `Start` is accepted at edge k+WIDTH+1 at the earliest.
- Operands are latched at issue; changes to A, B or Op during `Busy` have no effect on the result.
- State machine: IDLE → (accepted MULT/DIV) → RUN (counter 0 … WIDTH−1) → writeback on the last RUN edge → IDLE.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams `OP_ADD` … `OP_DIVU`
  - helper function `is_md_op(op)`
- Sub-module `md_iter`: iterative shift-add multiplier and restoring divider.
  - Shares one WIDTH+1-bit adder/subtractor.
  - Owns the counter, partial remainder/product, sign-fix logic and the `done` pulse.
- The top level contains the combinational op mux, the HI/LO registers and the `Start`/`Busy` gating.

## Test plan
- WIDTH=32, reset asserted mid-DIV at cycle 10 → `Busy`=0, HI=LO=0 while in reset. After release, MFLO → 0.
- Combinational sweep:
  - Op=5, A=4, B=0x8000_0000 → Out=0xF800_0000.
  - Op=7, A=−1, B=1 → Out=1.
  - Op=8, same A/B → Out=0; check `Zero`=1.
- MULT A=−3, B=7 with `Start` → `Busy` high 32 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. MULTU 0xFFFF_FFFF² → HI=0xFFFF_FFFE, LO=1.
- Divide cases:
  - DIV −7 ÷ 2 → LO=−3, HI=−1.
  - DIVU 7 ÷ 0 → LO=0xFFFF_FFFF, HI=7.
  - DIV 0x8000_0000 ÷ −1 → LO=0x8000_0000, HI=0.
- Second `Start` at cycle 5 of an active MULT → ignored; the result equals the first op's. MFHI during `Busy` returns the pre-op HI.
- WIDTH=8 instance: MULTU 200×3 → `Busy` for 8 cycles, HI=0x02, LO=0x58. Op=6, A=9 → shift by 1.
